// File: rtl/main_memory_responder.sv
// Main-memory responder: 4-phase request/stop handshake with programmable access latency.
// Optional out-of-range detection is enabled by defining MEM_BOUNDS_CHECK_EN.
module main_memory_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic [7:0]  mem_data_in [0:3],
    input  logic        interupt_start,
    output logic [7:0]  mem_data_out [0:3],
    output logic        interupt_stop,
    output logic        mem_busy,
    output logic        addr_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] word_q, word_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  oor_q, oor_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  stop_q, stop_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  wr_en_c;
    logic                  oor_c;
    logic                  unused_addr_c;

    logic [31:0] mem_q [DEPTH];

`ifdef MEM_BOUNDS_CHECK_EN
    assign oor_c = |mem_addr[31:ADDR_WIDTH+2];
`else
    assign oor_c = 1'b0;
`endif

    // Byte-offset bits never select anything; upper bits only matter with bounds checking.
    assign unused_addr_c = ^{mem_addr[1:0], mem_addr[31:ADDR_WIDTH+2]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        wr_en_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (interupt_start) begin
                    word_d  = mem_addr[ADDR_WIDTH+1:2];
                    we_d    = mem_we;
                    wdata_d = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};
                    oor_d   = oor_c;
                    // Every request passes through BUSY so stop always lands LATENCY edges after acceptance.
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (we_q) begin
                        wr_en_c = !oor_q;
                    end else begin
                        rdata_d = oor_q ? 32'h0 : mem_q[word_q];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (!interupt_start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        stop_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
        err_d  = stop_d && oor_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            stop_q  <= stop_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; reset still blocks a write that would complete on the same edge.
    always_ff @(posedge clk) begin
        if (reset && wr_en_c) begin
            mem_q[word_q] <= wdata_q;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_data_out[i] = rdata_q[8*i +: 8];
        end
    end

    assign interupt_stop = stop_q;
    assign mem_busy      = busy_q;
    assign addr_err      = err_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed handshake cases plus random traffic
// scored against an associative-array memory model.
module tb_main_memory_responder;

    localparam int unsigned AW    = 12;
    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_data_in [0:3];
    logic        interupt_start;
    logic [7:0]  mem_data_out [0:3];
    logic        interupt_stop;
    logic        mem_busy;
    logic        addr_err;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] model_mem [int unsigned];
    logic [31:0] last_rd;

    main_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_data_in    (mem_data_in),
        .interupt_start (interupt_start),
        .mem_data_out   (mem_data_out),
        .interupt_stop  (interupt_stop),
        .mem_busy       (mem_busy),
        .addr_err       (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic is_oor(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
        return (a >> (AW + 2)) != 32'h0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned key_of(input logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    function automatic logic [31:0] rd_word();
        return {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem_data_in[i] = w[8*i +: 8];
    endtask

    // Full handshake: start held until stop, then for 'hold' extra cycles, then released.
    task automatic txn(input string tag, input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input int hold);
        logic [31:0] exp_rd;
        logic        exp_err;
        exp_err = is_oor(addr);
        if (we) exp_rd = last_rd;
        else    exp_rd = exp_err ? 32'h0 : model_mem[key_of(addr)];
        mem_addr = addr;
        mem_we = we;
        set_data(wdata);
        interupt_start = 1'b1;
        step();
        chk({tag, ".busy_accept"}, 32'(mem_busy), 32'd1);
        chk({tag, ".stop_accept"}, 32'(interupt_stop), 32'd0);
        mem_addr = $urandom;
        mem_we = ~we;
        set_data($urandom);
        for (int i = 1; i < int'(LAT); i++) begin
            step();
            chk({tag, ".stop_early"}, 32'(interupt_stop), 32'd0);
        end
        step();
        chk({tag, ".stop_at_lat"}, 32'(interupt_stop), 32'd1);
        chk({tag, ".data"}, rd_word(), exp_rd);
        chk({tag, ".addr_err"}, 32'(addr_err), 32'(exp_err));
        if (we && !exp_err) model_mem[key_of(addr)] = wdata;
        last_rd = exp_rd;
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, ".stop_hold"}, 32'(interupt_stop), 32'd1);
            chk({tag, ".data_hold"}, rd_word(), exp_rd);
        end
        interupt_start = 1'b0;
        step();
        chk({tag, ".stop_release"}, 32'(interupt_stop), 32'd0);
        chk({tag, ".busy_release"}, 32'(mem_busy), 32'd0);
        chk({tag, ".data_idle"}, rd_word(), last_rd);
    endtask

    initial begin
        reset = 1'b0;
        interupt_start = 1'b0;
        mem_addr = '0;
        mem_we = 1'b0;
        set_data(32'h0);
        last_rd = 32'h0;

        repeat (3) step();
        reset = 1'b1;
        step();
        chk("reset.stop", 32'(interupt_stop), 32'd0);
        chk("reset.busy", 32'(mem_busy), 32'd0);
        chk("reset.err", 32'(addr_err), 32'd0);
        chk("reset.data", rd_word(), 32'h0);

        txn("wr10", 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0);
        txn("rd10", 32'h0000_0010, 1'b0, 32'h0, 0);
        chk("rd10.value", last_rd, 32'hDEAD_BEEF);
        txn("hold5", 32'h0000_0010, 1'b0, 32'h0, 5);

        // Start dropped mid-BUSY: write must still commit and stop pulses once.
        mem_addr = 32'h20;
        mem_we = 1'b1;
        set_data(32'h1122_3344);
        interupt_start = 1'b1;
        step();
        chk("abort.busy", 32'(mem_busy), 32'd1);
        interupt_start = 1'b0;
        for (int i = 1; i < int'(LAT); i++) begin
            step();
            chk("abort.stop_early", 32'(interupt_stop), 32'd0);
        end
        step();
        chk("abort.stop_pulse", 32'(interupt_stop), 32'd1);
        step();
        chk("abort.stop_end", 32'(interupt_stop), 32'd0);
        chk("abort.busy_end", 32'(mem_busy), 32'd0);
        model_mem[key_of(32'h20)] = 32'h1122_3344;
        txn("rd20", 32'h20, 1'b0, 32'h0, 1);

        // Reset during BUSY drops the pending write.
        txn("wr40a", 32'h40, 1'b1, 32'hAAAA_5555, 0);
        mem_addr = 32'h40;
        mem_we = 1'b1;
        set_data(32'h1234_5678);
        interupt_start = 1'b1;
        step();
        interupt_start = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        last_rd = 32'h0;
        chk("rstmid.stop", 32'(interupt_stop), 32'd0);
        chk("rstmid.busy", 32'(mem_busy), 32'd0);
        chk("rstmid.data", rd_word(), 32'h0);
        repeat (LAT + 1) begin
            step();
            chk("rstmid.no_stop", 32'(interupt_stop), 32'd0);
        end
        txn("rd40", 32'h40, 1'b0, 32'h0, 0);
        chk("rd40.value", last_rd, 32'hAAAA_5555);

        txn("wr4010", 32'h0000_4010, 1'b1, 32'hCAFE_F00D, 0);
        txn("rd10b", 32'h0000_0010, 1'b0, 32'h0, 0);
        txn("rd4010", 32'h0000_4010, 1'b0, 32'h0, 2);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic        we;
            a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 255)) << 20);
            we = 1'($urandom_range(0, 1));
            if (!we && !is_oor(a) && !model_mem.exists(key_of(a))) we = 1'b1;
            txn("rand", a, we, $urandom, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
